// File: rtl/rf_lockstep_check_if.sv
// Port bundle between a core wrapper and the lockstep register-file checker.
interface rf_lockstep_check_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned NRD    = 2,
  parameter int unsigned CNT_W  = 16
);
  logic                  wr;
  logic [ADDR_W-1:0]     wa;
  logic [DATA_W-1:0]     d;
  logic [NRD*ADDR_W-1:0] ra;
  logic [NRD-1:0]        rd_en;
  logic [NRD*DATA_W-1:0] dut_q;
  logic                  err_clr;
  logic [NRD*DATA_W-1:0] q;
  logic                  err;
  logic [CNT_W-1:0]      err_cnt;
  logic [1:0]            cap_port;
  logic [ADDR_W-1:0]     cap_addr;
  logic [DATA_W-1:0]     cap_exp;
  logic [DATA_W-1:0]     cap_act;

  modport master (
    output wr, wa, d, ra, rd_en, dut_q, err_clr,
    input  q, err, err_cnt, cap_port, cap_addr, cap_exp, cap_act
  );

  modport slave (
    input  wr, wa, d, ra, rd_en, dut_q, err_clr,
    output q, err, err_cnt, cap_port, cap_addr, cap_exp, cap_act
  );
endinterface

// File: rtl/rf_lockstep_check.sv
// Lockstep checker: golden shadow register file compared against a candidate's
// read ports through a latency-matched token pipeline, with first-mismatch capture.
module rf_lockstep_check #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 6,
  parameter int unsigned NRD      = 2,
  parameter int unsigned DUT_LAT  = 0,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned CNT_W    = 16
) (
  input logic               clk,
  input logic               reset,
  rf_lockstep_check_if.slave bus
);
  localparam int unsigned DEPTH = 2**ADDR_W;
  localparam int unsigned SUM_W = CNT_W + 3;
  localparam bit          ZR    = (ZERO_REG != 0);
  localparam logic [CNT_W-1:0] CMAX = '1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  vld;
  logic              wr_ok;

  logic [ADDR_W-1:0] rd_addr [NRD];
  logic [DATA_W-1:0] rd_data [NRD];
  logic [NRD-1:0]    rd_vld;

  logic [ADDR_W-1:0] c_addr [NRD];
  logic [DATA_W-1:0] c_data [NRD];
  logic [NRD-1:0]    c_en;
  logic [NRD-1:0]    c_vld;
  logic              c_occ;

  logic [NRD-1:0]    mm;
  logic              any_mm;
  logic [2:0]        n_mm;
  logic [1:0]        f_port;
  logic [ADDR_W-1:0] f_addr;
  logic [DATA_W-1:0] f_exp;
  logic [DATA_W-1:0] f_act;
  logic [SUM_W-1:0]  sum;
  logic [CNT_W-1:0]  cnt_nxt;

  logic              err_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [1:0]        cap_port_q;
  logic [ADDR_W-1:0] cap_addr_q;
  logic [DATA_W-1:0] cap_exp_q;
  logic [DATA_W-1:0] cap_act_q;

  // Register 0 is hardwired when ZERO_REG is set, so its writes never land.
  assign wr_ok = bus.wr && !(ZR && (bus.wa == '0));

  always_ff @(posedge clk)
    if (wr_ok) mem[bus.wa] <= bus.d;

  always_ff @(posedge clk or posedge reset)
    if (reset)      vld <= '0;
    else if (wr_ok) vld[bus.wa] <= 1'b1;

  // Combinational read; a same-cycle write is not yet visible.
  always_comb begin
    for (int p = 0; p < int'(NRD); p++) begin
      rd_addr[p] = bus.ra[p*ADDR_W +: ADDR_W];
      if (ZR && (rd_addr[p] == '0)) begin
        rd_data[p] = '0;
        rd_vld[p]  = 1'b1;
      end else begin
        rd_data[p] = mem[rd_addr[p]];
        rd_vld[p]  = vld[rd_addr[p]];
      end
    end
  end

  if (DUT_LAT == 0) begin : g_wire
    always_comb begin
      c_addr = rd_addr;
      c_data = rd_data;
      c_en   = bus.rd_en;
      c_vld  = rd_vld;
      c_occ  = 1'b1;
    end
  end else begin : g_pipe
    logic [ADDR_W-1:0] s_addr [DUT_LAT][NRD];
    logic [DATA_W-1:0] s_data [DUT_LAT][NRD];
    logic [NRD-1:0]    s_en   [DUT_LAT];
    logic [NRD-1:0]    s_vld  [DUT_LAT];
    logic              s_occ  [DUT_LAT];

    // Occupancy bits keep the compare stage idle until real tokens arrive after reset.
    always_ff @(posedge clk or posedge reset)
      if (reset) begin
        for (int s = 0; s < int'(DUT_LAT); s++) begin
          for (int p = 0; p < int'(NRD); p++) begin
            s_addr[s][p] <= '0;
            s_data[s][p] <= '0;
          end
          s_en[s]  <= '0;
          s_vld[s] <= '0;
          s_occ[s] <= 1'b0;
        end
      end else begin
        s_addr[0] <= rd_addr;
        s_data[0] <= rd_data;
        s_en[0]   <= bus.rd_en;
        s_vld[0]  <= rd_vld;
        s_occ[0]  <= 1'b1;
        for (int s = 1; s < int'(DUT_LAT); s++) begin
          s_addr[s] <= s_addr[s-1];
          s_data[s] <= s_data[s-1];
          s_en[s]   <= s_en[s-1];
          s_vld[s]  <= s_vld[s-1];
          s_occ[s]  <= s_occ[s-1];
        end
      end

    always_comb begin
      c_addr = s_addr[DUT_LAT-1];
      c_data = s_data[DUT_LAT-1];
      c_en   = s_en[DUT_LAT-1];
      c_vld  = s_vld[DUT_LAT-1];
      c_occ  = s_occ[DUT_LAT-1];
    end
  end

  // Per-port compare, mismatch count and lowest-index selection for capture.
  always_comb begin
    mm     = '0;
    n_mm   = '0;
    f_port = '0;
    f_addr = '0;
    f_exp  = '0;
    f_act  = '0;
    for (int p = 0; p < int'(NRD); p++) begin
      mm[p] = c_occ && c_en[p] && c_vld[p] &&
              (c_data[p] != bus.dut_q[p*DATA_W +: DATA_W]);
      n_mm  = n_mm + 3'(mm[p]);
    end
    for (int p = int'(NRD) - 1; p >= 0; p--) begin
      if (mm[p]) begin
        f_port = 2'(p);
        f_addr = c_addr[p];
        f_exp  = c_data[p];
        f_act  = bus.dut_q[p*DATA_W +: DATA_W];
      end
    end
    any_mm  = |mm;
    sum     = SUM_W'(bus.err_clr ? CNT_W'(0) : cnt_q) + SUM_W'(n_mm);
    cnt_nxt = (sum > SUM_W'(CMAX)) ? CMAX : CNT_W'(sum);
  end

  // A mismatch in the clear cycle takes priority over the clear.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      err_q      <= 1'b0;
      cnt_q      <= '0;
      cap_port_q <= '0;
      cap_addr_q <= '0;
      cap_exp_q  <= '0;
      cap_act_q  <= '0;
    end else begin
      err_q <= any_mm || (err_q && !bus.err_clr);
      cnt_q <= cnt_nxt;
      if (any_mm && (!err_q || bus.err_clr)) begin
        cap_port_q <= f_port;
        cap_addr_q <= f_addr;
        cap_exp_q  <= f_exp;
        cap_act_q  <= f_act;
      end else if (bus.err_clr) begin
        cap_port_q <= '0;
        cap_addr_q <= '0;
        cap_exp_q  <= '0;
        cap_act_q  <= '0;
      end
    end

  always_comb begin
    bus.q = '0;
    for (int p = 0; p < int'(NRD); p++) bus.q[p*DATA_W +: DATA_W] = c_data[p];
  end

  assign bus.err      = err_q;
  assign bus.err_cnt  = cnt_q;
  assign bus.cap_port = cap_port_q;
  assign bus.cap_addr = cap_addr_q;
  assign bus.cap_exp  = cap_exp_q;
  assign bus.cap_act  = cap_act_q;
endmodule

// File: tb/tb_rf_lockstep_check.sv
// Bench for rf_lockstep_check: three instances (latency 0/2/3, counter 16/16/2 bits)
// driven together and checked against a token-queue reference model.
`timescale 1ns/1ps
module tb_rf_lockstep_check;
  localparam int DW = 32;
  localparam int AW = 6;
  localparam int NR = 2;
  localparam int NI = 3;

  logic clk = 1'b0;
  logic reset;
  logic              wr_d;
  logic [AW-1:0]     wa_d;
  logic [DW-1:0]     d_d;
  logic [NR*AW-1:0]  ra_d;
  logic [NR-1:0]     en_d;
  logic [NR*DW-1:0]  dq [NI];
  logic              clr_d [NI];

  logic [NR*DW-1:0]  q_o [NI];
  logic              err_o [NI];
  logic [15:0]       cnt_o [NI];
  logic [1:0]        cport_o [NI];
  logic [AW-1:0]     caddr_o [NI];
  logic [DW-1:0]     cexp_o [NI];
  logic [DW-1:0]     cact_o [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_inst
    localparam int unsigned LAT = (g == 0) ? 0 : (g == 1) ? 2 : 3;
    localparam int unsigned CW  = (g == 2) ? 2 : 16;
    rf_lockstep_check_if #(.DATA_W(DW), .ADDR_W(AW), .NRD(NR), .CNT_W(CW)) bus ();
    rf_lockstep_check #(.DATA_W(DW), .ADDR_W(AW), .NRD(NR), .DUT_LAT(LAT),
                        .ZERO_REG(1), .CNT_W(CW))
      dut (.clk(clk), .reset(reset), .bus(bus));
    assign bus.wr      = wr_d;
    assign bus.wa      = wa_d;
    assign bus.d       = d_d;
    assign bus.ra      = ra_d;
    assign bus.rd_en   = en_d;
    assign bus.dut_q   = dq[g];
    assign bus.err_clr = clr_d[g];
    assign q_o[g]      = bus.q;
    assign err_o[g]    = bus.err;
    assign cnt_o[g]    = 16'(bus.err_cnt);
    assign cport_o[g]  = bus.cap_port;
    assign caddr_o[g]  = bus.cap_addr;
    assign cexp_o[g]   = bus.cap_exp;
    assign cact_o[g]   = bus.cap_act;
  end

  // A check token as the model sees it: what was read, and how the candidate will corrupt it.
  typedef struct packed {
    logic [NR-1:0]    en;
    logic [NR-1:0]    vld;
    logic [NR*AW-1:0] addr;
    logic [NR*DW-1:0] data;
    logic [NR*DW-1:0] flip;
    logic             clr;
  } stg_t;

  stg_t          pipe [NI][$];
  logic [DW-1:0] mem_m [64];
  bit            vld_m [64];
  bit            err_m [NI];
  int            cnt_m [NI];
  int            cport_m [NI];
  int            caddr_m [NI];
  logic [DW-1:0] cexp_m [NI];
  logic [DW-1:0] cact_m [NI];
  int            checks = 0;
  int            errors = 0;

  logic [AW-1:0] s_ra [NR];
  bit            s_en [NR];
  logic [DW-1:0] s_flip [NR];
  bit            s_clr;
  bit            s_wr;
  logic [AW-1:0] s_wa;
  logic [DW-1:0] s_d;

  function automatic int lat_of(int i);
    return (i == 0) ? 0 : (i == 1) ? 2 : 3;
  endfunction

  function automatic int cmax_of(int i);
    return (i == 2) ? 3 : 65535;
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    s_wr = 1'b0; s_wa = '0; s_d = '0; s_clr = 1'b0;
    for (int p = 0; p < NR; p++) begin
      s_ra[p] = '0; s_en[p] = 1'b0; s_flip[p] = '0;
    end
  endtask

  task automatic chk_state();
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("err%0d", i),   64'(err_o[i]),   64'(err_m[i]));
      chk($sformatf("cnt%0d", i),   64'(cnt_o[i]),   64'(cnt_m[i]));
      chk($sformatf("cport%0d", i), 64'(cport_o[i]), 64'(cport_m[i]));
      chk($sformatf("caddr%0d", i), 64'(caddr_o[i]), 64'(caddr_m[i]));
      chk($sformatf("cexp%0d", i),  64'(cexp_o[i]),  64'(cexp_m[i]));
      chk($sformatf("cact%0d", i),  64'(cact_o[i]),  64'(cact_m[i]));
    end
  endtask

  task automatic clear_model(int i);
    err_m[i] = 1'b0; cnt_m[i] = 0; cport_m[i] = 0; caddr_m[i] = 0;
    cexp_m[i] = '0; cact_m[i] = '0;
  endtask

  // Called at a falling edge; reset is held across one rising edge.
  task automatic do_reset();
    reset = 1'b1;
    wr_d = 1'b0; ra_d = '0; en_d = '0;
    for (int i = 0; i < NI; i++) begin
      clr_d[i] = 1'b0;
      dq[i] = {$urandom, $urandom};
      pipe[i].delete();
      clear_model(i);
    end
    for (int a = 0; a < 64; a++) vld_m[a] = 1'b0;
    #1;
    chk_state();
    for (int i = 1; i < NI; i++) chk($sformatf("q_rst%0d", i), 64'(q_o[i]), 64'(0));
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // One cycle: issue stimulus, present candidate data, check q then the registered state.
  task automatic tick();
    stg_t          cur, h;
    bit            occ, m;
    int            n, first;
    logic [DW-1:0] act, td;
    bit            qk [NI][NR];
    logic [DW-1:0] qe [NI][NR];
    cur = '0;
    for (int p = 0; p < NR; p++) begin
      cur.addr[p*AW +: AW] = s_ra[p];
      cur.en[p]            = s_en[p];
      cur.flip[p*DW +: DW] = s_flip[p];
      cur.vld[p]           = (s_ra[p] == '0) ? 1'b1 : vld_m[s_ra[p]];
      cur.data[p*DW +: DW] = (s_ra[p] == '0) ? '0 : mem_m[s_ra[p]];
      ra_d[p*AW +: AW]     = s_ra[p];
      en_d[p]              = s_en[p];
    end
    cur.clr = s_clr;
    wr_d = s_wr; wa_d = s_wa; d_d = s_d;
    for (int i = 0; i < NI; i++) begin
      pipe[i].push_back(cur);
      occ = (pipe[i].size() > lat_of(i));
      h = '0;
      if (occ) h = pipe[i].pop_front();
      clr_d[i] = occ && h.clr;
      if (clr_d[i]) clear_model(i);
      n = 0;
      first = -1;
      for (int p = 0; p < NR; p++) begin
        td  = h.data[p*DW +: DW];
        act = (occ && h.vld[p]) ? (td ^ h.flip[p*DW +: DW]) : DW'($urandom);
        dq[i][p*DW +: DW] = act;
        m = occ && h.en[p] && h.vld[p] && (act != td);
        qk[i][p] = occ ? h.vld[p] : (lat_of(i) > 0);
        qe[i][p] = occ ? td : '0;
        if (m) begin
          n++;
          if (first < 0) begin
            first = p;
            if (!err_m[i]) begin
              cport_m[i] = p;
              caddr_m[i] = int'(h.addr[p*AW +: AW]);
              cexp_m[i]  = td;
              cact_m[i]  = act;
            end
          end
        end
      end
      if (n > 0) begin
        err_m[i] = 1'b1;
        cnt_m[i] = (cnt_m[i] + n > cmax_of(i)) ? cmax_of(i) : cnt_m[i] + n;
      end
    end
    if (s_wr && (s_wa != '0)) begin
      mem_m[s_wa] = s_d;
      vld_m[s_wa] = 1'b1;
    end
    #1;
    for (int i = 0; i < NI; i++)
      for (int p = 0; p < NR; p++)
        if (qk[i][p]) chk($sformatf("q%0d_%0d", i, p), 64'(q_o[i][p*DW +: DW]), 64'(qe[i][p]));
    @(posedge clk);
    #1;
    chk_state();
    @(negedge clk);
  endtask

  task automatic drain();
    idle();
    repeat (4) tick();
  endtask

  initial begin
    reset = 1'b1;
    wr_d = 1'b0; wa_d = '0; d_d = '0; ra_d = '0; en_d = '0;
    for (int i = 0; i < NI; i++) begin clr_d[i] = 1'b0; dq[i] = '0; end
    for (int a = 0; a < 64; a++) begin mem_m[a] = '0; vld_m[a] = 1'b0; end
    idle();
    @(negedge clk);
    do_reset();

    // Matching read of a written register.
    idle(); s_wr = 1'b1; s_wa = 6'd5; s_d = 32'hDEADBEEF; tick();
    idle(); s_ra[0] = 6'd5; s_en[0] = 1'b1; tick();
    drain();
    for (int i = 0; i < NI; i++) begin
      chk("tp1_err", 64'(err_o[i]), 64'(0));
      chk("tp1_cnt", 64'(cnt_o[i]), 64'(0));
    end

    // Single mismatch on port 0.
    idle(); s_wr = 1'b1; s_wa = 6'd7; s_d = 32'h0; tick();
    idle(); s_ra[0] = 6'd7; s_en[0] = 1'b1; s_flip[0] = 32'h1; tick();
    drain();
    for (int i = 0; i < NI; i++) begin
      chk("tp2_err",   64'(err_o[i]),   64'(1));
      chk("tp2_cnt",   64'(cnt_o[i]),   64'(1));
      chk("tp2_cport", 64'(cport_o[i]), 64'(0));
      chk("tp2_caddr", 64'(caddr_o[i]), 64'(7));
      chk("tp2_cexp",  64'(cexp_o[i]),  64'(0));
      chk("tp2_cact",  64'(cact_o[i]),  64'(1));
    end

    // Both ports mismatch together, then a later mismatch leaves the capture alone.
    idle(); s_clr = 1'b1; tick();
    idle(); s_wr = 1'b1; s_wa = 6'd3; s_d = $urandom; tick();
    idle(); s_wr = 1'b1; s_wa = 6'd9; s_d = $urandom; tick();
    idle(); s_ra[0] = 6'd9; s_ra[1] = 6'd3; s_en[0] = 1'b1; s_en[1] = 1'b1;
    s_flip[0] = 32'h100; s_flip[1] = 32'h100; tick();
    drain();
    chk("tp3_cnt",   64'(cnt_o[1]),   64'(2));
    chk("tp3_cport", 64'(cport_o[1]), 64'(0));
    chk("tp3_caddr", 64'(caddr_o[1]), 64'(9));
    idle(); s_ra[1] = 6'd3; s_en[1] = 1'b1; s_flip[1] = 32'h8000_0000; tick();
    drain();
    chk("tp3_cnt_b",   64'(cnt_o[1]),   64'(3));
    chk("tp3_caddr_b", 64'(caddr_o[1]), 64'(9));
    chk("tp3_cnt_sat", 64'(cnt_o[2]),   64'(3));

    // Unwritten register and register 0 never flag.
    do_reset();
    idle(); s_ra[0] = 6'd12; s_en[0] = 1'b1; s_ra[1] = 6'd0; s_en[1] = 1'b1; tick();
    idle(); s_wr = 1'b1; s_wa = 6'd0; s_d = 32'h55; tick();
    idle(); s_ra[0] = 6'd0; s_en[0] = 1'b1; tick();
    drain();
    for (int i = 0; i < NI; i++) begin
      chk("tp4_err", 64'(err_o[i]), 64'(0));
      chk("tp4_cnt", 64'(cnt_o[i]), 64'(0));
    end

    // Clear arriving together with a new mismatch.
    idle(); s_wr = 1'b1; s_wa = 6'd20; s_d = 32'h1234_5678; tick();
    idle(); s_ra[1] = 6'd20; s_en[1] = 1'b1; s_flip[1] = 32'hF; tick();
    drain();
    idle(); s_ra[0] = 6'd20; s_en[0] = 1'b1; s_flip[0] = 32'hF0; s_clr = 1'b1; tick();
    drain();
    for (int i = 0; i < NI; i++) begin
      chk("tp5_err",   64'(err_o[i]),   64'(1));
      chk("tp5_cnt",   64'(cnt_o[i]),   64'(1));
      chk("tp5_cport", 64'(cport_o[i]), 64'(0));
      chk("tp5_caddr", 64'(caddr_o[i]), 64'(20));
      chk("tp5_cexp",  64'(cexp_o[i]),  64'(32'h1234_5678));
      chk("tp5_cact",  64'(cact_o[i]),  64'(32'h1234_5688));
    end

    // Five mismatches after a clear: the 2-bit counter saturates.
    idle(); s_clr = 1'b1; tick();
    for (int k = 0; k < 5; k++) begin
      idle(); s_ra[0] = 6'd20; s_en[0] = 1'b1; s_flip[0] = DW'(k + 1); tick();
    end
    drain();
    chk("tp6_cnt16", 64'(cnt_o[1]),  64'(5));
    chk("tp6_cnt2",  64'(cnt_o[2]),  64'(3));
    chk("tp6_cact",  64'(cact_o[1]), 64'(32'h1234_5679));

    // Random traffic with a reset while tokens are in flight.
    for (int c = 0; c < 300; c++) begin
      if (c == 150) do_reset();
      idle();
      s_wr = 1'($urandom_range(0, 1));
      s_wa = AW'($urandom_range(0, 15));
      s_d  = $urandom;
      for (int p = 0; p < NR; p++) begin
        s_ra[p]   = AW'($urandom_range(0, 15));
        s_en[p]   = 1'($urandom_range(0, 1));
        s_flip[p] = ($urandom_range(0, 7) == 0) ? DW'($urandom) : '0;
      end
      s_clr = ($urandom_range(0, 31) == 0);
      tick();
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rf_lockstep_check.md
# rf_lockstep_check

Parametrised lockstep checker for processor register files. It holds a golden shadow register file, mirrors every write, and compares each enabled read port against the read data returned by a candidate register file under test. The candidate may have up to three cycles of read latency. Mismatches are flagged, counted and captured. The block sits beside a candidate register file inside a core wrapper, replacing the ad-hoc XOR compare wrappers with a reusable, multi-port, latency-aware checker.

## Interface
Parameters:
- DATA_W, 32, register width
- ADDR_W, 6, address width; depth is 2**ADDR_W
- NRD, 2, number of read ports (1..4)
- DUT_LAT, 0, candidate read latency in cycles (0..3)
- ZERO_REG, 1, when 1, register 0 reads as 0 and writes to it are ignored
- CNT_W, 16, mismatch counter width

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high reset
- wr  in  1  write enable
- wa  in  ADDR_W  write address
- d  in  DATA_W  write data
- ra  in  NRD*ADDR_W  read addresses; port i occupies bits [i*ADDR_W +: ADDR_W]
- rd_en  in  NRD  per-port compare enable
- dut_q  in  NRD*DATA_W  candidate read data, arriving DUT_LAT cycles after ra
- err_clr  in  1  synchronous clear of err, err_cnt and the capture registers
- q  out  NRD*DATA_W  golden read data, aligned with dut_q
- err  out  1  sticky mismatch flag
- err_cnt  out  CNT_W  saturating mismatch count
- cap_port  out  2  port index of the first mismatch
- cap_addr  out  ADDR_W  address of the first mismatch
- cap_exp  out  DATA_W  expected data at the first mismatch
- cap_act  out  DATA_W  actual data at the first mismatch

## Operation
- Golden storage: 2**ADDR_W x DATA_W. Storage contents are not reset.
- Written-valid bits: one per entry, all cleared by reset. A bit is set on a write to its entry.
- ZERO_REG=1:
  - Entry 0 always reads 0 and is always valid.
  - Writes to address 0 are dropped and do not set its valid bit.
- Read semantics:
  - Combinational read of storage.
  - Read-during-write to the same address returns the OLD value; new data is visible the next cycle.
- Per port i, each cycle samples: ra[i], rd_en[i], golden data, and the valid bit. Together these form a "check token".
- Tokens pass through a DUT_LAT-deep pipeline. With DUT_LAT=0 the pipeline is a wire.
- Compare stage: a token mismatches when all of the following hold:
  - token enabled;
  - token valid (entry written since reset, or address 0 with ZERO_REG=1);
  - pipeline stage occupied;
  - token data != dut_q[i].
- q[i] is the token's golden data at the compare stage.
- err sets on any mismatch and stays set until err_clr or reset.
- err_cnt adds the number of mismatching ports in the cycle and saturates at 2**CNT_W-1.
- Capture:
  - Loaded only when err is currently 0 and a mismatch occurs.
  - When several ports mismatch in the same cycle, the lowest port index wins.
  - Held until err_clr or reset.
- err_clr with a simultaneous mismatch:
  - that cycle's mismatch wins: err=1 and capture reloads;
  - err_cnt is loaded with the number of mismatches in that cycle.

## Timing
- Reset values: err=0, err_cnt=0, cap_*=0, pipeline occupancy=0, all valid bits=0.
- q reset value: 0 when DUT_LAT>=1; when DUT_LAT=0, q follows the combinational read.
- Write: d is visible on reads starting from cycle t+1 after wr is high at cycle t.
- Read at cycle t: compared against dut_q at cycle t+DUT_LAT. err, err_cnt and cap_* update at the edge ending cycle t+DUT_LAT, so they are visible from t+DUT_LAT+1.
- Reset mid-operation:
  - In-flight tokens are discarded.
  - No compares occur for the first DUT_LAT cycles after reset deassertion.
- No backpressure: one token per port per cycle, and the pipeline never stalls.

## Test plan
- Write 0xDEADBEEF to reg 5, then read ra0=5 with DUT_LAT=2 and dut_q matching two cycles later -> err stays 0, err_cnt=0, q0=0xDEADBEEF at the compare cycle.
- Read reg 7 with dut_q=0x1, where reg 7 holds 0x0 after a write -> err=1 the following cycle, err_cnt=1, cap_port=0, cap_addr=7, cap_exp=0, cap_act=1.
- Both ports mismatch in the same cycle (port1 addr 3, port0 addr 9) -> err_cnt += 2, cap_port=0, cap_addr=9. A later mismatch leaves the capture unchanged.
- Read an unwritten reg 12 after reset with garbage dut_q, and read address 0 with ZERO_REG=1 with dut_q=0 -> no error. Write 0x55 to address 0, then read it with dut_q=0 -> no error.
- Assert err_clr in the same cycle as a new mismatch -> err=1, err_cnt=1, capture holds the new mismatch.
- Force CNT_W=2 with 5 mismatches -> err_cnt saturates at 3. Assert reset mid-stream with DUT_LAT=3 -> all outputs 0 and no compares for 3 cycles after reset deasserts.
